// File: rtl/alu_seq_if.sv
// -----------------------------------------------------------------------------
// alu_seq_if
// Request/response bundle between the instruction decoder (master) and the
// sequential ALU (slave).
//   Request : in_valid, in_ready, inst[OPW], operand_1[WIDTH], operand_2[WIDTH]
//   Response: out_valid, out_ready, sol[WIDTH], sol_hi[WIDTH],
//             flag_z, flag_n, flag_c, flag_v, err
// -----------------------------------------------------------------------------
interface alu_seq_if #(
    parameter int WIDTH = 8,
    parameter int OPW   = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [OPW-1:0]   inst;
    logic [WIDTH-1:0] operand_1;
    logic [WIDTH-1:0] operand_2;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sol;
    logic [WIDTH-1:0] sol_hi;
    logic             flag_z;
    logic             flag_n;
    logic             flag_c;
    logic             flag_v;
    logic             err;

    modport master (
        output in_valid, inst, operand_1, operand_2, out_ready,
        input  in_ready, out_valid, sol, sol_hi, flag_z, flag_n, flag_c, flag_v, err
    );

    modport slave (
        input  in_valid, inst, operand_1, operand_2, out_ready,
        output in_ready, out_valid, sol, sol_hi, flag_z, flag_n, flag_c, flag_v, err
    );
endinterface

// File: rtl/alu_seq.sv
// -----------------------------------------------------------------------------
// alu_seq
// Registered ALU with a valid/ready request side and a valid/ready result side.
// One operation in flight at a time: IDLE -> EXEC (or MUL -> EXEC) -> DONE.
// Opcodes: 0 PASS, 1 ADD, 2 SUB, 3 AND, 4 OR, 5 XOR, 6 SHL, 7 SHR, 8 MUL.
//
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset (release synchronised internally)
//   bus    alu_seq_if.slave: request (in_valid/in_ready/inst/operand_1/2) and
//          result (out_valid/out_ready/sol/sol_hi/flag_z/n/c/v/err)
//
// Build option: define ALU_MUL_EN to include the shift-add multiplier
// (WIDTH steps). Without it opcode 8 is illegal and sol_hi is tied to 0.
// -----------------------------------------------------------------------------
module alu_seq #(
    parameter int WIDTH = 8,
    parameter int OPW   = 8
) (
    input  logic     clk,
    input  logic     rst_n,
    alu_seq_if.slave bus
);
    localparam int SHW = $clog2(WIDTH);

    localparam logic [OPW-1:0] OP_PASS = OPW'(0);
    localparam logic [OPW-1:0] OP_ADD  = OPW'(1);
    localparam logic [OPW-1:0] OP_SUB  = OPW'(2);
    localparam logic [OPW-1:0] OP_AND  = OPW'(3);
    localparam logic [OPW-1:0] OP_OR   = OPW'(4);
    localparam logic [OPW-1:0] OP_XOR  = OPW'(5);
    localparam logic [OPW-1:0] OP_SHL  = OPW'(6);
    localparam logic [OPW-1:0] OP_SHR  = OPW'(7);
    localparam logic [OPW-1:0] OP_MUL  = OPW'(8);

    typedef enum logic [1:0] {
        S_IDLE,
        S_EXEC,
        S_DONE
`ifdef ALU_MUL_EN
        , S_MUL
`endif
    } state_t;

    state_t           state_q, state_d;
    logic [OPW-1:0]   op_q, op_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic [WIDTH-1:0] sol_q, sol_d;
    logic [WIDTH-1:0] sol_hi_q, sol_hi_d;
    logic             z_q, z_d, n_q, n_d, c_q, c_d, v_q, v_d, err_q, err_d;
    logic             rst_meta_q, rst_meta_d, rst_ok_q, rst_ok_d;

`ifdef ALU_MUL_EN
    localparam int CNTW = $clog2(WIDTH) + 1;
    logic [2*WIDTH-1:0] prod_q, prod_d;
    logic [CNTW-1:0]    cnt_q, cnt_d;
    logic [WIDTH:0]     mul_sum;
`endif

    // Result of the latched operation (combinational, committed in EXEC)
    logic [WIDTH-1:0] res_sol, res_hi;
    logic             res_z, res_n, res_c, res_v, res_err;
    logic [WIDTH:0]   add_full, sub_full;
    logic [SHW-1:0]   sh_amt;
    logic             accept;

    // Reset release is walked through two flops so that the first accept
    // never happens on the same edge the asynchronous reset deasserts.
    assign rst_meta_d = 1'b1;
    assign rst_ok_d   = rst_meta_q;

    assign accept   = (state_q == S_IDLE) && rst_ok_q && bus.in_valid;
    assign add_full = {1'b0, a_q} + {1'b0, b_q};
    assign sub_full = {1'b0, a_q} - {1'b0, b_q};   // MSB is the borrow (A < B)
    assign sh_amt   = b_q[SHW-1:0];

`ifdef ALU_MUL_EN
    // One shift-add step: conditionally add A into the upper half, then
    // shift the whole {carry, hi, lo} right; lo starts out holding B.
    assign mul_sum = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, a_q} : '0);
`endif

    always_comb begin
        res_sol = '0;
        res_hi  = '0;
        res_c   = 1'b0;
        res_v   = 1'b0;
        res_err = 1'b0;
        case (op_q)
            OP_PASS: res_sol = a_q;
            OP_ADD: begin
                res_sol = add_full[WIDTH-1:0];
                res_c   = add_full[WIDTH];
                res_v   = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (add_full[WIDTH-1] != a_q[WIDTH-1]);
            end
            OP_SUB: begin
                res_sol = sub_full[WIDTH-1:0];
                res_c   = sub_full[WIDTH];
                res_v   = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (sub_full[WIDTH-1] != a_q[WIDTH-1]);
            end
            OP_AND:  res_sol = a_q & b_q;
            OP_OR:   res_sol = a_q | b_q;
            OP_XOR:  res_sol = a_q ^ b_q;
            OP_SHL:  res_sol = a_q << sh_amt;
            OP_SHR:  res_sol = a_q >> sh_amt;
            OP_MUL: begin
`ifdef ALU_MUL_EN
                res_sol = prod_q[WIDTH-1:0];
                res_hi  = prod_q[2*WIDTH-1:WIDTH];
                res_c   = |prod_q[2*WIDTH-1:WIDTH];
`else
                res_err = 1'b1;
`endif
            end
            default: res_err = 1'b1;
        endcase
        // Illegal ops report all flags clear, so Z is suppressed as well
        res_z = !res_err && (res_sol == '0);
        res_n = res_sol[WIDTH-1];
    end

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        sol_d    = sol_q;
        sol_hi_d = sol_hi_q;
        z_d      = z_q;
        n_d      = n_q;
        c_d      = c_q;
        v_d      = v_q;
        err_d    = err_q;
`ifdef ALU_MUL_EN
        prod_d   = prod_q;
        cnt_d    = cnt_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    op_d    = bus.inst;
                    a_d     = bus.operand_1;
                    b_d     = bus.operand_2;
                    state_d = S_EXEC;
`ifdef ALU_MUL_EN
                    if (bus.inst == OP_MUL) begin
                        state_d = S_MUL;
                        cnt_d   = '0;
                        prod_d  = {{WIDTH{1'b0}}, bus.operand_2};
                    end
`endif
                end
            end
            // Common commit point for every op, including MUL after its steps
            S_EXEC: begin
                sol_d    = res_sol;
                sol_hi_d = res_hi;
                z_d      = res_z;
                n_d      = res_n;
                c_d      = res_c;
                v_d      = res_v;
                err_d    = res_err;
                state_d  = S_DONE;
            end
`ifdef ALU_MUL_EN
            S_MUL: begin
                prod_d = {mul_sum, prod_q[WIDTH-1:1]};
                cnt_d  = cnt_q + 1'b1;
                if (cnt_q == CNTW'(WIDTH - 1)) begin
                    state_d = S_EXEC;
                end
            end
`endif
            S_DONE: begin
                if (bus.out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            op_q       <= '0;
            a_q        <= '0;
            b_q        <= '0;
            sol_q      <= '0;
            sol_hi_q   <= '0;
            z_q        <= 1'b0;
            n_q        <= 1'b0;
            c_q        <= 1'b0;
            v_q        <= 1'b0;
            err_q      <= 1'b0;
            rst_meta_q <= 1'b0;
            rst_ok_q   <= 1'b0;
`ifdef ALU_MUL_EN
            prod_q     <= '0;
            cnt_q      <= '0;
`endif
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            a_q        <= a_d;
            b_q        <= b_d;
            sol_q      <= sol_d;
            sol_hi_q   <= sol_hi_d;
            z_q        <= z_d;
            n_q        <= n_d;
            c_q        <= c_d;
            v_q        <= v_d;
            err_q      <= err_d;
            rst_meta_q <= rst_meta_d;
            rst_ok_q   <= rst_ok_d;
`ifdef ALU_MUL_EN
            prod_q     <= prod_d;
            cnt_q      <= cnt_d;
`endif
        end
    end

    assign bus.in_ready  = (state_q == S_IDLE);
    assign bus.out_valid = (state_q == S_DONE);
    assign bus.sol       = sol_q;
`ifdef ALU_MUL_EN
    assign bus.sol_hi    = sol_hi_q;
`else
    assign bus.sol_hi    = '0;
`endif
    assign bus.flag_z    = z_q;
    assign bus.flag_n    = n_q;
    assign bus.flag_c    = c_q;
    assign bus.flag_v    = v_q;
    assign bus.err       = err_q;
endmodule
